// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed, checksummed image into memory and verifies it by readback
module program_loader #(
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [9:0]  in_data,
    output logic        in_ready,
    output logic        m_write,
    output logic [13:0] m_inaddr,
    output logic [9:0]  m_indata,
    output logic        m_read,
    output logic [13:0] m_outaddr,
    input  logic [9:0]  m_outdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [9:0]  count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [13:0] BASE = 14'(BASE_ADDR);

    state_t      state;
    logic [9:0]  len_n;
    logic [9:0]  idx;
    logic [9:0]  sum;
    logic [9:0]  csum;
    logic [9:0]  rd_idx;
    logic [9:0]  samp_cnt;
    logic        samp_valid;
    logic [9:0]  rb_sum;

    logic        xfer;
    logic [14:0] len_last;
    logic        len_bad;
    logic [9:0]  rb_next;

    assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign xfer     = in_valid && in_ready;

    // One bit wider than the address so an image running past the top of memory is visible.
    assign len_last = {1'b0, BASE} + {5'b0, in_data} - 15'd1;
    assign len_bad  = (in_data == 10'd0) || (len_last > 15'd16383);
    assign rb_next  = rb_sum + m_outdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            m_write    <= 1'b0;
            m_inaddr   <= '0;
            m_indata   <= '0;
            m_read     <= 1'b0;
            m_outaddr  <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            len_n      <= '0;
            idx        <= '0;
            sum        <= '0;
            csum       <= '0;
            rd_idx     <= '0;
            samp_cnt   <= '0;
            samp_valid <= 1'b0;
            rb_sum     <= '0;
        end else begin
            m_write <= 1'b0;
            m_read  <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state   <= S_LEN;
                        count   <= '0;
                        sum     <= '0;
                        idx     <= '0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        cpu_rst <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state   <= S_ERROR;
                            error   <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            len_n <= in_data;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        m_write  <= 1'b1;
                        m_inaddr <= BASE + {4'b0, idx};
                        m_indata <= in_data;
                        count    <= count + 10'd1;
                        sum      <= sum + in_data;
                        idx      <= idx + 10'd1;
                        if (idx == len_n - 10'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        csum <= in_data;
                        if (in_data != sum) begin
                            state   <= S_ERROR;
                            error   <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            // First read goes out on the very first VERIFY cycle.
                            state      <= S_VERIFY;
                            m_read     <= 1'b1;
                            m_outaddr  <= BASE;
                            rd_idx     <= 10'd1;
                            samp_cnt   <= '0;
                            samp_valid <= 1'b0;
                            rb_sum     <= '0;
                        end
                    end
                end
                S_VERIFY: begin
                    // Read data lags the strobe by one cycle, so the sample qualifier is the delayed strobe.
                    samp_valid <= m_read;
                    if (rd_idx != len_n) begin
                        m_read    <= 1'b1;
                        m_outaddr <= BASE + {4'b0, rd_idx};
                        rd_idx    <= rd_idx + 10'd1;
                    end
                    if (samp_valid) begin
                        rb_sum   <= rb_next;
                        samp_cnt <= samp_cnt + 10'd1;
                        if (samp_cnt == len_n - 10'd1) begin
                            if (rb_next == csum) begin
                                state   <= S_DONE;
                                done    <= 1'b1;
                                cpu_rst <= 1'b0;
                            end else begin
                                state   <= S_ERROR;
                                error   <= 1'b1;
                                cpu_rst <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [9:0]  in_data;
    logic        in_ready, m_write, m_read, cpu_rst, done, error;
    logic [13:0] m_inaddr, m_outaddr;
    logic [9:0]  m_indata, m_outdata, count;

    logic        hi_in_ready, hi_m_write, hi_m_read, hi_cpu_rst, hi_done, hi_error;
    logic [13:0] hi_m_inaddr, hi_m_outaddr;
    logic [9:0]  hi_m_indata, hi_count;

    logic [9:0]  mem [0:16383];
    logic        corrupt;

    int n_cmp = 0;
    int n_bad = 0;

    int wr_cnt, rd_cnt, overlap, hi_wr_cnt;
    int wr_addr [16];
    int wr_data [16];
    int wr_count [16];
    int rd_addr [16];
    int hi_first_addr, hi_last_addr;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
        .m_read(m_read), .m_outaddr(m_outaddr), .m_outdata(m_outdata),
        .cpu_rst(cpu_rst), .done(done), .error(error), .count(count)
    );

    program_loader #(.BASE_ADDR(16382)) dut_hi (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(hi_in_ready), .m_write(hi_m_write), .m_inaddr(hi_m_inaddr), .m_indata(hi_m_indata),
        .m_read(hi_m_read), .m_outaddr(hi_m_outaddr), .m_outdata(10'd0),
        .cpu_rst(hi_cpu_rst), .done(hi_done), .error(hi_error), .count(hi_count)
    );

    always @(posedge clk) begin
        if (m_write) mem[m_inaddr] <= m_indata;
        if (m_read) m_outdata <= mem[m_outaddr] ^ ((corrupt && m_outaddr == 14'd1) ? 10'd1 : 10'd0);
    end

    always @(negedge clk) begin
        if (m_write) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt]  = int'(m_inaddr);
                wr_data[wr_cnt]  = int'(m_indata);
                wr_count[wr_cnt] = int'(count);
            end
            wr_cnt++;
        end
        if (m_read) begin
            if (rd_cnt < 16) rd_addr[rd_cnt] = int'(m_outaddr);
            rd_cnt++;
        end
        if (m_write && m_read) overlap++;
        if (hi_m_write) begin
            if (hi_wr_cnt == 0) hi_first_addr = int'(hi_m_inaddr);
            hi_last_addr = int'(hi_m_inaddr);
            hi_wr_cnt++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0; rd_cnt = 0; overlap = 0; hi_wr_cnt = 0;
        hi_first_addr = -1; hi_last_addr = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [9:0] w, input bit gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        step();
        if (gap) begin
            in_valid = 1'b0;
            step();
        end
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done || error) && n < 40) begin
            step();
            n++;
        end
        chk("wait_timeout", int'(n < 40), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_m_write"}, int'(m_write), 0);
        chk({tag, "_m_inaddr"}, int'(m_inaddr), 0);
        chk({tag, "_m_indata"}, int'(m_indata), 0);
        chk({tag, "_m_read"}, int'(m_read), 0);
        chk({tag, "_m_outaddr"}, int'(m_outaddr), 0);
        chk({tag, "_cpu_rst"}, int'(cpu_rst), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_count"}, int'(count), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; corrupt = 1'b0;
        clear_logs();
        repeat (2) step();
        check_reset_vals("rst0");
        rst = 1'b0;

        // Good image 3,5,7,9 with checksum 21
        clear_logs();
        pulse_start();
        chk("t1_ready_len", int'(in_ready), 1);
        send(10'd3, 0); send(10'd5, 0); send(10'd7, 0); send(10'd9, 0); send(10'd21, 0);
        in_valid = 1'b0;
        chk("t1_read0", int'(m_read), 1);
        chk("t1_raddr0", int'(m_outaddr), 0);
        repeat (3) step();
        chk("t1_done_early", int'(done), 0);
        step();
        chk("t1_done", int'(done), 1);
        chk("t1_cpu_rst", int'(cpu_rst), 0);
        chk("t1_error", int'(error), 0);
        chk("t1_count", int'(count), 3);
        chk("t1_wr_cnt", wr_cnt, 3);
        chk("t1_wa0", wr_addr[0], 0); chk("t1_wd0", wr_data[0], 5);
        chk("t1_wa1", wr_addr[1], 1); chk("t1_wd1", wr_data[1], 7);
        chk("t1_wa2", wr_addr[2], 2); chk("t1_wd2", wr_data[2], 9);
        chk("t1_wcount0", wr_count[0], 1);
        chk("t1_rd_cnt", rd_cnt, 3);
        chk("t1_ra0", rd_addr[0], 0); chk("t1_ra1", rd_addr[1], 1); chk("t1_ra2", rd_addr[2], 2);
        chk("t1_overlap", overlap, 0);
        chk("hi_n3_error", int'(hi_error), 1);
        chk("hi_n3_writes", hi_wr_cnt, 0);
        step();
        chk("t1_done_held", int'(done), 1);

        // Bad checksum
        clear_logs();
        pulse_start();
        chk("t2_done_cleared", int'(done), 0);
        send(10'd3, 0); send(10'd5, 0); send(10'd7, 0); send(10'd9, 0); send(10'd22, 0);
        in_valid = 1'b0;
        chk("t2_error", int'(error), 1);
        chk("t2_cpu_rst", int'(cpu_rst), 1);
        chk("t2_done", int'(done), 0);
        repeat (5) step();
        chk("t2_wr_cnt", wr_cnt, 3);
        chk("t2_rd_cnt", rd_cnt, 0);

        // Zero length
        clear_logs();
        pulse_start();
        send(10'd0, 0);
        in_valid = 1'b0;
        chk("t3_error", int'(error), 1);
        chk("t3_ready", int'(in_ready), 0);
        repeat (3) step();
        chk("t3_wr_cnt", wr_cnt, 0);

        // Stalled stream with wrapping checksum; high-base instance fits exactly
        clear_logs();
        pulse_start();
        send(10'd2, 1); send(10'd1000, 1); send(10'd100, 1); send(10'd76, 1);
        wait_end(n);
        chk("t4_done", int'(done), 1);
        chk("t4_error", int'(error), 0);
        chk("t4_wr_cnt", wr_cnt, 2);
        chk("t4_wa0", wr_addr[0], 0); chk("t4_wd0", wr_data[0], 1000);
        chk("t4_wa1", wr_addr[1], 1); chk("t4_wd1", wr_data[1], 100);
        chk("t4_hi_writes", hi_wr_cnt, 2);
        chk("t4_hi_first", hi_first_addr, 16382);
        chk("t4_hi_last", hi_last_addr, 16383);

        // Reset in the middle of a load, with a transfer offered on the reset cycle
        clear_logs();
        pulse_start();
        send(10'd4, 0); send(10'd11, 0); send(10'd22, 0);
        in_data = 10'd33;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("t5_rst");
        repeat (3) step();
        chk("t5_wr_cnt", wr_cnt, 2);
        clear_logs();
        pulse_start();
        send(10'd4, 0); send(10'd1, 0); send(10'd2, 0); send(10'd3, 0); send(10'd4, 0); send(10'd10, 0);
        in_valid = 1'b0;
        wait_end(n);
        chk("t5_done", int'(done), 1);
        chk("t5_count", int'(count), 4);
        chk("t5_wr_cnt", wr_cnt, 4);

        // Corrupted readback at address 1
        clear_logs();
        corrupt = 1'b1;
        pulse_start();
        send(10'd3, 0); send(10'd5, 0); send(10'd7, 0); send(10'd9, 0); send(10'd21, 0);
        in_valid = 1'b0;
        wait_end(n);
        chk("t6_latency", n, 4);
        chk("t6_error", int'(error), 1);
        chk("t6_done", int'(done), 0);
        chk("t6_cpu_rst", int'(cpu_rst), 1);
        chk("t6_rd_cnt", rd_cnt, 3);
        corrupt = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0, first memory address written (0..16383).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE, ERROR.
REQ-005 in_valid  input  1  stream word available.
REQ-006 in_data  input  10  stream word.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 m_write  output  1  memory write-port strobe.
REQ-009 m_inaddr  output  14  memory write address.
REQ-010 m_indata  output  10  memory write data.
REQ-011 m_read  output  1  memory read-port strobe.
REQ-012 m_outaddr  output  14  memory read address.
REQ-013 m_outdata  input  10  memory read data; valid the cycle after m_read.
REQ-014 cpu_rst  output  1  hold cpu in reset while high.
REQ-015 done  output  1  image loaded and verified.
REQ-016 error  output  1  load aborted.
REQ-017 count  output  10  number of data words written so far.

Function
REQ-018 States SHALL be IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERROR.
REQ-019 Transfer SHALL occur on a cycle with in_valid && in_ready; in_ready SHALL be 1 exactly in LEN, DATA, CSUM (decoded from state register) and 0 otherwise.
REQ-020 IDLE/DONE/ERROR + start -> LEN next cycle; count, sum, index cleared; done, error cleared; cpu_rst set to 1.
REQ-021 LEN: transferred word is N; N=0 or BASE_ADDR+N-1 > 16383 -> ERROR, else store N -> DATA.
REQ-022 DATA: each transferred word W with index i SHALL produce, on the next cycle, a one-cycle m_write=1, m_inaddr=BASE_ADDR+i, m_indata=W; count increments in that same cycle.
REQ-023 DATA: sum SHALL accumulate W modulo 1024 (10-bit wrap); after word N-1 transferred -> CSUM.
REQ-024 CSUM: transferred word C stored; C != sum -> ERROR with no reads issued; C == sum -> VERIFY.
REQ-025 VERIFY: m_read=1 for N consecutive cycles with m_outaddr=BASE_ADDR, BASE_ADDR+1, ...; m_outdata sampled one cycle after each read and summed modulo 1024 into a cleared readback sum.
REQ-026 After the Nth readback sample, readback sum == C -> DONE, else ERROR.
REQ-027 DONE: done=1, cpu_rst=0, error=0, held until start or rst.
REQ-028 ERROR: error=1, cpu_rst=1, done=0, held until start or rst.
REQ-029 m_write and m_read SHALL never be asserted in the same cycle, and neither outside DATA/VERIFY (write pulse may trail last DATA transfer by one cycle into CSUM).
REQ-030 start SHALL be ignored in LEN, DATA, CSUM, VERIFY.
REQ-031 Stalls (in_valid low) SHALL hold state, count, sum unchanged; no write issued.

Reset
REQ-032 rst SHALL force IDLE; in_ready=0, m_write=0, m_inaddr=0, m_indata=0, m_read=0, m_outaddr=0, cpu_rst=1, done=0, error=0, count=0.
REQ-033 rst mid-load SHALL take priority over any transfer that cycle; words already written stay in memory, no further writes.

Verification
REQ-034 BASE_ADDR=0, start, stream 3,5,7,9,21 -> writes (0,5),(1,7),(2,9); reads addr 0..2; done=1, cpu_rst=0, count=3.
REQ-035 Stream 3,5,7,9,22 -> three writes, no m_read, error=1, cpu_rst=1.
REQ-036 Stream 0 -> ERROR the cycle after length transfer, no writes; BASE_ADDR=16382 with N=3 -> ERROR, no writes.
REQ-037 Stream 2,1000,100,76 with in_valid toggling every other cycle -> writes (0,1000),(1,100), checksum wraps to 76, done=1.
REQ-038 rst asserted after second DATA word of N=4 load -> next cycle all outputs at reset values, no further m_write; subsequent start + full stream completes with done=1.
REQ-039 Memory model returning corrupted word at readback of addr 1 -> error=1 after third read sample, done=0.
